// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD start controller: FSM encoding and parameter defaults.
// The watchdog default exists only when GCD_TIMEOUT_EN is defined.
package gcd_pkg;

    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned DB_COUNT_DEF = 50000;
    localparam int unsigned CNT_W_DEF    = 16;
`ifdef GCD_TIMEOUT_EN
    localparam int unsigned TIMEOUT_DEF  = 1024;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // BUSY covers LOAD through WAIT_DONE
    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_START) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, stability counter, debounced level
// and single-cycle press pulse. A press is only reported once the button has been
// seen released after reset, so a button held through reset does not fire.
module btn_debounce
    import gcd_pkg::*;
#(
    parameter int unsigned DB_COUNT = DB_COUNT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_c
);

    logic [1:0]       sync_q;
    logic [1:0]       vld_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             armed_q, armed_d;

    // Debounce counter, level toggle and release-seen arming
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_COUNT - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // vld_q marks that the synchronizer holds real samples, not reset zeros
        armed_d = armed_q | (vld_q[1] & ~sync_q[1] & ~level_q);
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            vld_q       <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_i};
            vld_q       <= {vld_q[0], 1'b1};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            armed_q     <= armed_d;
        end
    end

    assign level_o = level_q;
    assign press_c = level_q & ~level_dly_q & armed_q;

endmodule

// File: rtl/gcd_start_ctrl.sv
// GCD front end: debounced start button, synchronized operand capture, zero-operand
// rejection and START pulse generation. Define GCD_TIMEOUT_EN to add a WAIT_DONE
// watchdog (TIMEOUT_CYCLES); without it TIMEOUT is tied low.
module gcd_start_ctrl
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH          = WIDTH_DEF,
    parameter int unsigned DB_COUNT       = DB_COUNT_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
`ifdef GCD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             BTN_RAW,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Y_IN,
    input  logic             DONE_IN,
    output logic [WIDTH-1:0] X_OUT,
    output logic [WIDTH-1:0] Y_OUT,
    output logic             START_OUT,
    output logic             BUSY,
    output logic             ERR_ZERO,
    output logic             TIMEOUT
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_s1_q, x_s2_q, y_s1_q, y_s2_q;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             start_q, busy_q;
    logic             err_q, err_d;
    logic             first_q;
    logic             db_level;
    logic             press_c;

    btn_debounce #(
        .DB_COUNT (DB_COUNT),
        .CNT_W    (CNT_W)
    ) u_db (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .btn_i   (BTN_RAW),
        .level_o (db_level),
        .press_c (press_c)
    );

`ifdef GCD_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q, timeout_d;
`endif

    // Next-state, operand capture and sticky flag updates
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
`ifdef GCD_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                x_d = x_s2_q;
                y_d = y_s2_q;
                if ((x_s2_q == '0) || (y_s2_q == '0)) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    err_d   = 1'b0;
`ifdef GCD_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // first WAIT cycle blanks a DONE left over from the previous run
                if (!first_q && DONE_IN) begin
                    state_d = ST_RELEASE;
                end
`ifdef GCD_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                if (!db_level) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchronizers and registered Moore outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            x_s1_q  <= '0;
            x_s2_q  <= '0;
            y_s1_q  <= '0;
            y_s2_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_s1_q  <= X_IN;
            x_s2_q  <= x_s1_q;
            y_s1_q  <= Y_IN;
            y_s2_q  <= y_s1_q;
            x_q     <= x_d;
            y_q     <= y_d;
            start_q <= (state_d == ST_START);
            busy_q  <= is_busy(state_d);
            err_q   <= err_d;
            first_q <= (state_q == ST_START);
        end
    end

`ifdef GCD_TIMEOUT_EN
    // Watchdog counter runs only while waiting for DONE
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= (state_q == ST_WAIT) ? to_cnt_q + TO_W'(1) : '0;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign X_OUT     = x_q;
    assign Y_OUT     = y_q;
    assign START_OUT = start_q;
    assign BUSY      = busy_q;
    assign ERR_ZERO  = err_q;

endmodule

// File: tb/tb_gcd_start_ctrl.sv
// Directed bench for gcd_start_ctrl with DB_COUNT=4 (and TIMEOUT_CYCLES=8 when
// GCD_TIMEOUT_EN is defined). Inputs change right after a falling edge; outputs
// are sampled on the falling edge.
module tb_gcd_start_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       BTN_RAW = 1'b0;
    logic [3:0] X_IN = 4'd0;
    logic [3:0] Y_IN = 4'd0;
    logic       DONE_IN = 1'b0;
    logic [3:0] X_OUT, Y_OUT;
    logic       START_OUT, BUSY, ERR_ZERO, TIMEOUT;

    int n_cmp = 0;
    int n_bad = 0;

    gcd_start_ctrl #(
        .WIDTH    (4),
        .DB_COUNT (4),
        .CNT_W    (4)
`ifdef GCD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .BTN_RAW   (BTN_RAW),
        .X_IN      (X_IN),
        .Y_IN      (Y_IN),
        .DONE_IN   (DONE_IN),
        .X_OUT     (X_OUT),
        .Y_OUT     (Y_OUT),
        .START_OUT (START_OUT),
        .BUSY      (BUSY),
        .ERR_ZERO  (ERR_ZERO),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic release_btn();
        BTN_RAW = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (X_OUT !== 4'd0)    begin n_bad++; $display("FAIL reset_x: got %0d want 0", X_OUT); end
        n_cmp++; if (Y_OUT !== 4'd0)    begin n_bad++; $display("FAIL reset_y: got %0d want 0", Y_OUT); end
        n_cmp++; if (START_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", START_OUT); end
        n_cmp++; if (BUSY !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (ERR_ZERO !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ERR_ZERO); end
        n_cmp++; if (TIMEOUT !== 1'b0)  begin n_bad++; $display("FAIL reset_timeout: got %b want 0", TIMEOUT); end
        X_IN = 4'd1;
        Y_IN = 4'd1;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int at = 0;
        for (int i = 0; i < 10; i++) begin
            BTN_RAW = (i % 2 == 0);
            tick();
            n_cmp++; if (START_OUT !== 1'b0) begin n_bad++; $display("FAIL bounce_no_start[%0d]: got %b want 0", i, START_OUT); end
        end
        BTN_RAW = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (START_OUT === 1'b1) begin pulses++; at = k; end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
        n_cmp++; if (at != 8)     begin n_bad++; $display("FAIL bounce_latency: got %0d want 8", at); end
        n_cmp++; if (BUSY !== 1'b1)    begin n_bad++; $display("FAIL bounce_busy: got %b want 1", BUSY); end
        n_cmp++; if (X_OUT !== 4'd1)   begin n_bad++; $display("FAIL bounce_x: got %0d want 1", X_OUT); end
        DONE_IN = 1'b1;
        repeat (3) tick();
        n_cmp++; if (BUSY !== 1'b0)    begin n_bad++; $display("FAIL bounce_done_busy: got %b want 0", BUSY); end
        DONE_IN = 1'b0;
        release_btn();
    endtask

    task automatic test_capture();
        X_IN = 4'd12;
        Y_IN = 4'd8;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (7) tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL cap_load_busy: got %b want 1", BUSY); end
        n_cmp++; if (START_OUT !== 1'b0) begin n_bad++; $display("FAIL cap_load_start: got %b want 0", START_OUT); end
        tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL cap_start: got %b want 1", START_OUT); end
        n_cmp++; if (X_OUT !== 4'd12)    begin n_bad++; $display("FAIL cap_x: got %0d want 12", X_OUT); end
        n_cmp++; if (Y_OUT !== 4'd8)     begin n_bad++; $display("FAIL cap_y: got %0d want 8", Y_OUT); end
        X_IN = 4'd3;
        tick();
        n_cmp++; if (START_OUT !== 1'b0) begin n_bad++; $display("FAIL cap_start_one_cycle: got %b want 0", START_OUT); end
        repeat (4) tick();
        n_cmp++; if (X_OUT !== 4'd12)    begin n_bad++; $display("FAIL cap_x_frozen: got %0d want 12", X_OUT); end
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL cap_wait_busy: got %b want 1", BUSY); end
        DONE_IN = 1'b1;
        tick();
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL cap_done_busy: got %b want 0", BUSY); end
        n_cmp++; if (X_OUT !== 4'd12)    begin n_bad++; $display("FAIL cap_x_after_done: got %0d want 12", X_OUT); end
        DONE_IN = 1'b0;
        release_btn();
    endtask

    task automatic test_zero();
        int pulses = 0;
        X_IN = 4'd0;
        Y_IN = 4'd5;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (7) tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL zero_load_busy: got %b want 1", BUSY); end
        tick();
        n_cmp++; if (ERR_ZERO !== 1'b1)  begin n_bad++; $display("FAIL zero_err: got %b want 1", ERR_ZERO); end
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL zero_busy: got %b want 0", BUSY); end
        n_cmp++; if (X_OUT !== 4'd0)     begin n_bad++; $display("FAIL zero_x: got %0d want 0", X_OUT); end
        n_cmp++; if (Y_OUT !== 4'd5)     begin n_bad++; $display("FAIL zero_y: got %0d want 5", Y_OUT); end
        if (START_OUT === 1'b1) pulses++;
        repeat (5) begin tick(); if (START_OUT === 1'b1) pulses++; end
        n_cmp++; if (pulses != 0)        begin n_bad++; $display("FAIL zero_no_start: got %0d pulses want 0", pulses); end
        release_btn();
        X_IN = 4'd9;
        Y_IN = 4'd6;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL zero_next_start: got %b want 1", START_OUT); end
        n_cmp++; if (ERR_ZERO !== 1'b0)  begin n_bad++; $display("FAIL zero_err_clear: got %b want 0", ERR_ZERO); end
        n_cmp++; if (X_OUT !== 4'd9)     begin n_bad++; $display("FAIL zero_next_x: got %0d want 9", X_OUT); end
        DONE_IN = 1'b1;
        repeat (3) tick();
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL zero_next_done: got %b want 0", BUSY); end
        release_btn();
    endtask

    task automatic test_blanking();
        int pulses = 0;
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL blank_idle_busy: got %b want 0", BUSY); end
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL blank_start: got %b want 1", START_OUT); end
        tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL blank_wait1_busy: got %b want 1", BUSY); end
        tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL blank_wait2_busy: got %b want 1", BUSY); end
        tick();
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL blank_exit_busy: got %b want 0", BUSY); end
        repeat (20) begin tick(); if (START_OUT === 1'b1) pulses++; end
        n_cmp++; if (pulses != 0)        begin n_bad++; $display("FAIL blank_held_no_repeat: got %0d pulses want 0", pulses); end
        DONE_IN = 1'b0;
        release_btn();
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL blank_repress_start: got %b want 1", START_OUT); end
        DONE_IN = 1'b1;
        repeat (3) tick();
        release_btn();
        DONE_IN = 1'b0;
    endtask

`ifdef GCD_TIMEOUT_EN
    task automatic test_timeout();
        X_IN = 4'd5;
        Y_IN = 4'd3;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL to_start: got %b want 1", START_OUT); end
        repeat (8) tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL to_busy_before: got %b want 1", BUSY); end
        n_cmp++; if (TIMEOUT !== 1'b0)   begin n_bad++; $display("FAIL to_early: got %b want 0", TIMEOUT); end
        tick();
        n_cmp++; if (TIMEOUT !== 1'b1)   begin n_bad++; $display("FAIL to_set: got %b want 1", TIMEOUT); end
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL to_busy_after: got %b want 0", BUSY); end
        release_btn();
        n_cmp++; if (TIMEOUT !== 1'b1)   begin n_bad++; $display("FAIL to_sticky: got %b want 1", TIMEOUT); end
        X_IN = 4'd7;
        Y_IN = 4'd2;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL to_next_start: got %b want 1", START_OUT); end
        n_cmp++; if (TIMEOUT !== 1'b0)   begin n_bad++; $display("FAIL to_clear: got %b want 0", TIMEOUT); end
        DONE_IN = 1'b1;
        repeat (3) tick();
        release_btn();
        DONE_IN = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        X_IN = 4'd5;
        Y_IN = 4'd3;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL nto_start: got %b want 1", START_OUT); end
        repeat (40) tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL nto_still_waiting: got %b want 1", BUSY); end
        n_cmp++; if (TIMEOUT !== 1'b0)   begin n_bad++; $display("FAIL nto_timeout: got %b want 0", TIMEOUT); end
        DONE_IN = 1'b1;
        repeat (3) tick();
        release_btn();
        DONE_IN = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        int pulses = 0;
        X_IN = 4'd10;
        Y_IN = 4'd4;
        repeat (3) tick();
        BTN_RAW = 1'b1;
        repeat (9) tick();
        n_cmp++; if (BUSY !== 1'b1)      begin n_bad++; $display("FAIL rmid_wait_busy: got %b want 1", BUSY); end
        n_cmp++; if (X_OUT !== 4'd10)    begin n_bad++; $display("FAIL rmid_x: got %0d want 10", X_OUT); end
        #2 RESET_N = 1'b0;
        #1;
        n_cmp++; if (X_OUT !== 4'd0)     begin n_bad++; $display("FAIL rmid_x_rst: got %0d want 0", X_OUT); end
        n_cmp++; if (Y_OUT !== 4'd0)     begin n_bad++; $display("FAIL rmid_y_rst: got %0d want 0", Y_OUT); end
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL rmid_busy_rst: got %b want 0", BUSY); end
        n_cmp++; if (START_OUT !== 1'b0) begin n_bad++; $display("FAIL rmid_start_rst: got %b want 0", START_OUT); end
        n_cmp++; if (ERR_ZERO !== 1'b0)  begin n_bad++; $display("FAIL rmid_err_rst: got %b want 0", ERR_ZERO); end
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (20) begin tick(); if (START_OUT === 1'b1) pulses++; end
        n_cmp++; if (pulses != 0)        begin n_bad++; $display("FAIL rmid_held_no_start: got %0d pulses want 0", pulses); end
        n_cmp++; if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL rmid_held_busy: got %b want 0", BUSY); end
        release_btn();
        BTN_RAW = 1'b1;
        repeat (8) tick();
        n_cmp++; if (START_OUT !== 1'b1) begin n_bad++; $display("FAIL rmid_repress_start: got %b want 1", START_OUT); end
        n_cmp++; if (X_OUT !== 4'd10)    begin n_bad++; $display("FAIL rmid_repress_x: got %0d want 10", X_OUT); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_capture();
        test_zero();
        test_blanking();
`ifdef GCD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
